// File: rtl/vib_axi_pkg.sv
// Shared AXI constants and S2MM FSM encoding for the vibration capture datapath.
package vib_axi_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2,
    StResp = 2'd3
  } s2mm_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic int unsigned bytes_per_beat(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/s2mm_burst_controller.sv
// Moves the AXI-Stream sample stream into ring-buffer slots as AXI3 INCR write bursts,
// one burst outstanding, pulsing SM_writing once per accepted data beat.
module s2mm_burst_controller
  import vib_axi_pkg::*;
#(
  parameter int unsigned MM_ADDR_WIDTH = 32,
  parameter int unsigned MM_DATA_WIDTH = 64,
  parameter int unsigned LOG_BURST_LEN = 4
) (
  input  logic                       SYS_aclk,
  input  logic                       SYS_aresetn,
  input  logic                       S2MM_enable,
  input  logic [4:0]                 SM_log_length,
  input  logic [MM_ADDR_WIDTH-1:0]   SM_write_buffer,
  output logic                       SM_writing,
  input  logic [MM_DATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic                       S_AXIS_tvalid,
  output logic                       S_AXIS_tready,
  output logic [MM_ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [3:0]                 M_AXI_awlen,
  output logic [2:0]                 M_AXI_awsize,
  output logic [1:0]                 M_AXI_awburst,
  output logic                       M_AXI_awvalid,
  input  logic                       M_AXI_awready,
  output logic [MM_DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [MM_DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                       M_AXI_wlast,
  output logic                       M_AXI_wvalid,
  input  logic                       M_AXI_wready,
  input  logic [1:0]                 M_AXI_bresp,
  input  logic                       M_AXI_bvalid,
  output logic                       M_AXI_bready,
  output logic                       S2MM_busy,
  output logic                       S2MM_error
);

  localparam int unsigned BurstLen = 1 << LOG_BURST_LEN;
  localparam int unsigned Bytes    = bytes_per_beat(MM_DATA_WIDTH);
  localparam int unsigned SizeLog  = $clog2(Bytes);
  localparam int unsigned OffW     = 23;

  s2mm_state_e              state_q, state_d;
  logic [MM_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [MM_ADDR_WIDTH-1:0] buf_base_q, buf_base_d;
  logic [LOG_BURST_LEN-1:0] beat_cnt_q, beat_cnt_d;
  logic [OffW-1:0]          buf_offset_q, buf_offset_d;
  logic [4:0]               log_len_q, log_len_d;
  logic                     writing_q, writing_d;
  logic                     error_q, error_d;

  logic beat_acc, last_beat, wrap, len_ok, enter_addr;

  assign beat_acc  = (state_q == StData) & S_AXIS_tvalid & M_AXI_wready;
  assign last_beat = (beat_cnt_q == LOG_BURST_LEN'(BurstLen - 1));
  assign len_ok    = (SM_log_length >= 5'(LOG_BURST_LEN));
  // Buffer ends when the burst just completed reaches 2**log_len beats.
  assign wrap      = (({9'd0, buf_offset_q} + 32'(BurstLen)) == (32'd1 << log_len_q));

  always_comb begin
    state_d      = state_q;
    awaddr_d     = awaddr_q;
    buf_base_d   = buf_base_q;
    beat_cnt_d   = beat_cnt_q;
    buf_offset_d = buf_offset_q;
    log_len_d    = log_len_q;
    error_d      = error_q;
    writing_d    = beat_acc;
    enter_addr   = 1'b0;

    case (state_q)
      StIdle: begin
        if (S2MM_enable) begin
          if (len_ok) enter_addr = 1'b1;
          else        error_d    = 1'b1;
        end
      end
      StAddr: begin
        if (M_AXI_awready) state_d = StData;
      end
      StData: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) state_d = StResp;
        end
      end
      StResp: begin
        if (M_AXI_bvalid) begin
          if (M_AXI_bresp != RESP_OKAY) error_d = 1'b1;
          buf_offset_d = wrap ? '0 : buf_offset_q + OffW'(BurstLen);
          if (!S2MM_enable) begin
            state_d = StIdle;
          end else if ((buf_offset_d == '0) && !len_ok) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else begin
            enter_addr = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Slot base and size only change at a buffer start, so a buffer is never split.
    if (enter_addr) begin
      state_d = StAddr;
      if (buf_offset_d == '0) begin
        buf_base_d = SM_write_buffer;
        log_len_d  = SM_log_length;
      end
      awaddr_d = buf_base_d + (MM_ADDR_WIDTH'(buf_offset_d) << SizeLog);
    end
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      state_q      <= StIdle;
      awaddr_q     <= '0;
      buf_base_q   <= '0;
      beat_cnt_q   <= '0;
      buf_offset_q <= '0;
      log_len_q    <= '0;
      writing_q    <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      awaddr_q     <= awaddr_d;
      buf_base_q   <= buf_base_d;
      beat_cnt_q   <= beat_cnt_d;
      buf_offset_q <= buf_offset_d;
      log_len_q    <= log_len_d;
      writing_q    <= writing_d;
      error_q      <= error_d;
    end
  end

  assign M_AXI_awaddr  = awaddr_q;
  assign M_AXI_awlen   = 4'(BurstLen - 1);
  assign M_AXI_awsize  = 3'(SizeLog);
  assign M_AXI_awburst = BURST_INCR;
  assign M_AXI_awvalid = (state_q == StAddr);
  assign M_AXI_wdata   = S_AXIS_tdata;
  assign M_AXI_wstrb   = '1;
  assign M_AXI_wvalid  = (state_q == StData) & S_AXIS_tvalid;
  assign M_AXI_wlast   = (state_q == StData) & last_beat;
  assign S_AXIS_tready = (state_q == StData) & M_AXI_wready;
  assign M_AXI_bready  = (state_q == StResp);
  assign SM_writing    = writing_q;
  assign S2MM_busy     = (state_q != StIdle);
  assign S2MM_error    = error_q;

endmodule

// File: tb/tb_s2mm_burst_controller.sv
// Bench for s2mm_burst_controller: acts as stream source and AXI slave, scoreboards
// write data and burst addresses against bench-side expectations.
module tb_s2mm_burst_controller;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          enable;
  logic [4:0]    log_len;
  logic [AW-1:0] wbuf;
  logic          writing;
  logic [DW-1:0] tdata;
  logic          tvalid, tready;
  logic [AW-1:0] awaddr;
  logic [3:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [7:0]    wstrb;
  logic          wlast, wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic          busy, error;

  s2mm_burst_controller dut (
    .SYS_aclk       (clk),
    .SYS_aresetn    (rst_n),
    .S2MM_enable    (enable),
    .SM_log_length  (log_len),
    .SM_write_buffer(wbuf),
    .SM_writing     (writing),
    .S_AXIS_tdata   (tdata),
    .S_AXIS_tvalid  (tvalid),
    .S_AXIS_tready  (tready),
    .M_AXI_awaddr   (awaddr),
    .M_AXI_awlen    (awlen),
    .M_AXI_awsize   (awsize),
    .M_AXI_awburst  (awburst),
    .M_AXI_awvalid  (awvalid),
    .M_AXI_awready  (awready),
    .M_AXI_wdata    (wdata),
    .M_AXI_wstrb    (wstrb),
    .M_AXI_wlast    (wlast),
    .M_AXI_wvalid   (wvalid),
    .M_AXI_wready   (wready),
    .M_AXI_bresp    (bresp),
    .M_AXI_bvalid   (bvalid),
    .M_AXI_bready   (bready),
    .S2MM_busy      (busy),
    .S2MM_error     (error)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] aw_exp_q[$];
  logic [DW-1:0] data_q[$];
  int            w_beats, aw_count, b_count, n_writing, err_burst;
  bit            bp, b_pend, aw_stall, t_acc;
  logic [AW-1:0] aw_hold;
  logic [DW-1:0] next_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample registered outputs, drive new inputs, then score this cycle's handshakes.
  task automatic step();
    @(posedge clk);
    #1;
    if (writing) n_writing++;
    tvalid  = (tvalid && !t_acc) || !bp || ($urandom_range(0, 3) != 0);
    tdata   = next_data;
    wready  = !bp || ($urandom_range(0, 2) != 0);
    awready = !bp || ($urandom_range(0, 2) != 0);
    bvalid  = b_pend && (bvalid || !bp || ($urandom_range(0, 1) != 0));
    bresp   = (b_count == err_burst) ? 2'b10 : 2'b00;
    #1;
    t_acc = tvalid && tready;
    if (t_acc) begin
      data_q.push_back(tdata);
      next_data = {$urandom, $urandom};
    end
    if (awvalid) begin
      if (aw_stall) check("aw_stable", awaddr, aw_hold);
      aw_hold  = awaddr;
      aw_stall = !awready;
      if (awready) begin
        aw_count++;
        check("aw_expected", aw_exp_q.size() > 0, 1);
        if (aw_exp_q.size() > 0) check("awaddr", awaddr, aw_exp_q.pop_front());
      end
    end else begin
      aw_stall = 1'b0;
    end
    if (wvalid && wready) begin
      check("w_expected", data_q.size() > 0, 1);
      if (data_q.size() > 0) check("wdata", wdata, data_q.pop_front());
      check("wlast", wlast, (w_beats % 16) == 15);
      if ((w_beats % 16) == 15) b_pend = 1'b1;
      w_beats++;
    end
    if (bvalid && bready) begin
      b_pend = 1'b0;
      b_count++;
    end
  endtask

  task automatic run_beats(input int n);
    int guard = 0;
    while (w_beats < n && guard < 4000) begin
      step();
      guard++;
    end
    check("beats_reached", w_beats >= n, 1);
  endtask

  task automatic run_idle();
    int guard = 0;
    do begin
      step();
      guard++;
    end while (busy && guard < 2000);
    step();
    check("idle_reached", busy, 0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    enable  = 1'b0;
    tvalid  = 1'b0;
    wready  = 1'b0;
    awready = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    aw_exp_q.delete();
    data_q.delete();
    w_beats = 0; aw_count = 0; b_count = 0; n_writing = 0; err_burst = -1;
    b_pend = 1'b0; aw_stall = 1'b0; t_acc = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    next_data = 64'h0123_4567_89ab_cdef;
    log_len   = 5'd6;
    wbuf      = 32'h1000_0000;
    bp        = 1'b0;
    do_reset();
    #1;
    check("rst_busy", busy, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_error", error, 0);
    check("rst_writing", writing, 0);
    check("rst_awaddr", awaddr, 0);
    check("awlen", awlen, 15);
    check("awsize", awsize, 3);
    check("awburst", awburst, 1);
    check("wstrb", wstrb, 8'hff);

    // Four bursts fill a 64-beat buffer, then the mid-buffer base change takes effect.
    aw_exp_q = '{32'h1000_0000, 32'h1000_0080, 32'h1000_0100, 32'h1000_0180, 32'h2000_0000};
    enable = 1'b1;
    while (aw_count < 1) step();
    wbuf = 32'h2000_0000;
    run_beats(80);
    enable = 1'b0;
    run_idle();
    check("t2_aw_count", aw_count, 5);
    check("t2_writing", n_writing, 80);
    check("t2_beats", w_beats, 80);
    check("t2_aw_left", aw_exp_q.size(), 0);

    // Random backpressure on every channel.
    do_reset();
    bp   = 1'b1;
    wbuf = 32'h3000_0000;
    aw_exp_q = '{32'h3000_0000, 32'h3000_0080, 32'h3000_0100, 32'h3000_0180,
                 32'h3000_0000, 32'h3000_0080};
    enable = 1'b1;
    run_beats(96);
    enable = 1'b0;
    run_idle();
    check("t3_aw_count", aw_count, 6);
    check("t3_writing", n_writing, 96);
    check("t3_bursts", b_count, 6);
    bp = 1'b0;

    // Enable dropped mid-burst, then resumed at the next offset.
    do_reset();
    wbuf = 32'h4000_0000;
    aw_exp_q.push_back(32'h4000_0000);
    enable = 1'b1;
    run_beats(5);
    enable = 1'b0;
    run_idle();
    check("t4_beats", w_beats, 16);
    check("t4_bursts", b_count, 1);
    aw_exp_q.push_back(32'h4000_0080);
    enable = 1'b1;
    run_beats(32);
    enable = 1'b0;
    run_idle();
    check("t4_aw_count", aw_count, 2);

    // SLVERR on the second burst: sticky error, streaming continues.
    do_reset();
    wbuf      = 32'h5000_0000;
    err_burst = 1;
    aw_exp_q  = '{32'h5000_0000, 32'h5000_0080, 32'h5000_0100};
    enable = 1'b1;
    run_beats(17);
    check("t5_err_before", error, 0);
    run_beats(48);
    enable = 1'b0;
    run_idle();
    check("t5_err_sticky", error, 1);
    check("t5_aw_count", aw_count, 3);

    // Config error, then reset in the middle of a data phase.
    do_reset();
    log_len = 5'd3;
    wbuf    = 32'h6000_0000;
    enable  = 1'b1;
    repeat (10) step();
    check("t6_no_aw", aw_count, 0);
    check("t6_cfg_err", error, 1);
    check("t6_idle", busy, 0);
    log_len = 5'd6;
    aw_exp_q.push_back(32'h6000_0000);
    run_beats(3);
    check("t6_err_kept", error, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_awvalid", awvalid, 0);
    check("mid_rst_wvalid", wvalid, 0);
    check("mid_rst_tready", tready, 0);
    check("mid_rst_bready", bready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_writing", writing, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
